tx_client_arb: RTL
==================

Name: tx_client_arb

Overview:
- Shares one Ethernet transmit path (tx_req/tx_ack/tx_len/tx_strobe/packet_out handshake) among n_clients packet-producing clients, e.g. several mem_gateway instances or other UDP clients.
- Round-robin arbitration at packet granularity.
- Presents a single client-style interface to the MAC side.
- Routes the ack and strobes only to the granted client and muxes that client's bytes back out.

Parameters:
- n_clients, 4, number of requesting clients (2..8).
- jumbo_dw, 14, width of the packet length fields.
- idw, 3, width of the grant index (must satisfy 2**idw >= n_clients).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- c_tx_req  in  n_clients  per-client transmit request.
- c_tx_len  in  n_clients*jumbo_dw  per-client packet length, client k at bits [k*jumbo_dw +: jumbo_dw].
- c_packet_out  in  n_clients*8  per-client byte stream, client k at bits [k*8 +: 8].
- c_tx_ack  out  n_clients  ack pulse, routed to the granted client only.
- c_tx_strobe  out  n_clients  byte strobe, routed to the granted client only.
- tx_req  out  1  request to MAC.
- tx_len  out  jumbo_dw  length of the granted packet, held through the packet.
- packet_out  out  8  byte stream from the granted client.
- tx_ack  in  1  MAC accept pulse.
- tx_strobe  in  1  MAC byte strobe.
- grant_id  out  idw  index of the current or last grant.
- busy  out  1  high in any state other than IDLE.
- zero_len_err  out  1  sticky; set when a request is dropped because its length is 0.

Behaviour:
- Reset values:
  - tx_req=0, tx_len=0, c_tx_ack=0, c_tx_strobe=0, busy=0, zero_len_err=0.
  - grant_id=n_clients-1, so client 0 wins the first arbitration.
  - state=IDLE, byte counter=0.
- Clearing zero_len_err: rst only.
- States: IDLE, REQ, SEND, TAIL.
- IDLE:
  - Scans c_tx_req starting at grant_id+1, wrapping modulo n_clients; the first asserted request wins.
  - If the winner's c_tx_len==0: do not grant, set zero_len_err, set grant_id=winner (so it loses priority), stay in IDLE.
  - Otherwise: latch the winner into grant_id, latch its length into tx_len, set byte counter=0, go to REQ.
  - Arbitration takes 1 cycle. tx_req rises the cycle after the winning request is seen.
- REQ:
  - tx_req=1.
  - If c_tx_req[grant_id] falls before tx_ack arrives: drop tx_req, go to IDLE. grant_id keeps the withdrawn client, so round-robin advances past it.
  - On tx_ack=1: c_tx_ack[grant_id]=tx_ack combinationally (same cycle); tx_req drops next cycle; go to SEND.
  - tx_ack seen while in IDLE, SEND or TAIL is ignored and not forwarded.
- SEND:
  - c_tx_strobe[grant_id]=tx_strobe combinationally; all other clients' strobes are 0.
  - Counter increments per strobe.
  - When the strobe brings the count to tx_len, go to TAIL.
- TAIL:
  - Lasts exactly 1 cycle, because a client's byte is valid on the cycle after its strobe.
  - Any tx_strobe here is ignored and not forwarded.
  - Next state: IDLE.
- packet_out:
  - Combinational mux c_packet_out[grant_id] in SEND and TAIL; 8'h00 in IDLE and REQ.
  - The grant index must not change from the first strobe until TAIL ends.
- Packet spacing: with back-to-back requesters, the next tx_req rises 2 cycles after TAIL.
- Counter width: jumbo_dw. tx_len up to 2**jumbo_dw-1 is supported; no wrap inside a packet.
- Simultaneous events:
  - A request arriving during SEND waits for the next IDLE.
  - Newly asserted requests have no priority over older ones; order is purely rotational.
- rst mid-packet:
  - All outputs take their reset values on the next edge.
  - The granted client sees its strobes stop. Client recovery is outside this block.

Decomposition:
- Shared package: state encoding constants (IDLE, REQ, SEND, TAIL) and the default jumbo_dw.
- One natural sub-module: rr_pick. Combinational round-robin priority encoder with inputs req vector and last index, outputs winner index and valid. Reusable by other arbiters in the tree.

Test Plan:
- Single client 0, len=72; MAC acks 3 cycles after tx_req, then issues 72 consecutive strobes.
  - Required: tx_len=72 and grant_id=0.
  - Required: c_tx_ack[0] pulses once.
  - Required: the 72 bytes captured at packet_out one cycle after each strobe equal client 0's stream.
  - Required: busy falls 2 cycles after the last strobe.
- Clients 1 and 2 request in the same cycle after reset, lengths 16 and 24.
  - Required: client 1 is served first (16 strobes), then client 2 (24 strobes).
  - Required: c_tx_strobe[2] stays 0 throughout client 1's packet.
- All 4 clients request continuously, len=8 each, for 12 packets.
  - Required: grant order 0,1,2,3,0,1,2,3,0,1,2,3.
  - Required: gap between consecutive tx_req rises equals ack latency + 8 + 3 cycles.
- Client 3 raises c_tx_req, then drops it in REQ before tx_ack.
  - Required: tx_req drops the next cycle; no c_tx_ack pulse.
  - Required: a pending client 0 is granted next.
- Client 0 requests with len=0 while client 1 requests with len=4.
  - Required: zero_len_err=1; client 0 gets no ack.
  - Required: client 1 is served with 4 strobes.
- rst asserted at strobe 10 of a 72-byte packet.
  - Required: next cycle tx_req=0, c_tx_strobe=0, busy=0, grant_id=n_clients-1.
  - Required: a fresh request from client 0 is then granted normally.

Source files
------------

// File: rtl/tx_client_arb_pkg.sv
// Shared definitions for the transmit-path client arbiter.
package tx_client_arb_pkg;

    // Arbiter states: scan, wait for MAC accept, stream bytes, last-byte cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEND = 2'd2,
        ST_TAIL = 2'd3
    } arb_state_t;

    localparam int JUMBO_DW_DEFAULT = 14;

endpackage

// File: rtl/tx_client_arb_rr_pick.sv
// Combinational round-robin priority encoder: the first asserted request
// strictly after index 'last', wrapping modulo n_clients, wins.
module rr_pick #(
    parameter int n_clients = 4,
    parameter int idw       = 3
) (
    input  logic [n_clients-1:0] req,
    input  logic [idw-1:0]       last,
    output logic [idw-1:0]       winner,
    output logic                 valid
);

    logic [2*n_clients-1:0] dbl;
    logic [n_clients-1:0]   rot;
    int                     pos;
    int                     sum;

    // Rotate the request vector so bit 0 is the slot after 'last', then take the lowest set bit.
    always_comb begin
        dbl    = {req, req};
        rot    = n_clients'(dbl >> (int'(last) + 1));
        pos    = 0;
        valid  = |rot;
        for (int i = n_clients - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = i;
            end
        end
        sum = int'(last) + 1 + pos;
        if (sum >= n_clients) begin
            sum = sum - n_clients;
        end
        winner = idw'(sum);
    end

endmodule

// File: rtl/tx_client_arb.sv
// Packet-granular round-robin sharing of one MAC transmit path among
// several clients; ack/strobe go only to the granted client and its
// bytes are muxed back out.
module tx_client_arb
    import tx_client_arb_pkg::*;
#(
    parameter int n_clients = 4,
    parameter int jumbo_dw  = JUMBO_DW_DEFAULT,
    parameter int idw       = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [n_clients-1:0]          c_tx_req,
    input  logic [n_clients*jumbo_dw-1:0] c_tx_len,
    input  logic [n_clients*8-1:0]        c_packet_out,
    output logic [n_clients-1:0]          c_tx_ack,
    output logic [n_clients-1:0]          c_tx_strobe,
    output logic                          tx_req,
    output logic [jumbo_dw-1:0]           tx_len,
    output logic [7:0]                    packet_out,
    input  logic                          tx_ack,
    input  logic                          tx_strobe,
    output logic [idw-1:0]                grant_id,
    output logic                          busy,
    output logic                          zero_len_err
);

    // Slots padded to 2**idw so the grant index addresses them without range gaps.
    localparam int n_slots = 1 << idw;

    arb_state_t          state_reg, state_next;
    logic [idw-1:0]      grant_reg, grant_next;
    logic [jumbo_dw-1:0] len_reg, len_next;
    logic [jumbo_dw-1:0] count_reg, count_next;
    logic                zerr_reg, zerr_next;

    logic [n_slots-1:0]  req_slot;
    logic [7:0]          byte_slot [n_slots];
    logic [jumbo_dw-1:0] len_slot  [n_slots];
    logic [n_clients-1:0] sel;

    logic [idw-1:0]      pick_winner;
    logic                pick_valid;
    logic                ack_route;
    logic                strobe_route;
    logic                data_route;

    genvar gi;
    generate
        for (gi = 0; gi < n_slots; gi++) begin : g_slot
            if (gi < n_clients) begin : g_used
                assign req_slot[gi]  = c_tx_req[gi];
                assign byte_slot[gi] = c_packet_out[gi*8 +: 8];
                assign len_slot[gi]  = c_tx_len[gi*jumbo_dw +: jumbo_dw];
            end else begin : g_pad
                assign req_slot[gi]  = 1'b0;
                assign byte_slot[gi] = 8'h00;
                assign len_slot[gi]  = '0;
            end
        end
        for (gi = 0; gi < n_clients; gi++) begin : g_sel
            assign sel[gi] = (grant_reg == idw'(gi));
        end
    endgenerate

    rr_pick #(
        .n_clients (n_clients),
        .idw       (idw)
    ) u_pick (
        .req    (c_tx_req),
        .last   (grant_reg),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // State and datapath registers; reset leaves grant at the last client so client 0 goes first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            grant_reg <= idw'(n_clients - 1);
            len_reg   <= '0;
            count_reg <= '0;
            zerr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            len_reg   <= len_next;
            count_reg <= count_next;
            zerr_reg  <= zerr_next;
        end
    end

    // Next-state logic and routing enables for ack, strobe and byte mux.
    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        len_next     = len_reg;
        count_next   = count_reg;
        zerr_next    = zerr_reg;
        ack_route    = 1'b0;
        strobe_route = 1'b0;
        data_route   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    // A zero-length winner still takes the grant index so it loses priority next scan.
                    grant_next = pick_winner;
                    if (len_slot[pick_winner] == '0) begin
                        zerr_next = 1'b1;
                    end else begin
                        len_next   = len_slot[pick_winner];
                        count_next = '0;
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // A withdrawn request beats a same-cycle ack: nothing is forwarded.
                if (!req_slot[grant_reg]) begin
                    state_next = ST_IDLE;
                end else if (tx_ack) begin
                    ack_route  = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                data_route = 1'b1;
                if (tx_strobe) begin
                    strobe_route = 1'b1;
                    count_next   = count_reg + 1'b1;
                    if (count_next == len_reg) begin
                        state_next = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                // Client's last byte is valid here, one cycle after its strobe.
                data_route = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign tx_req       = (state_reg == ST_REQ);
    assign busy         = (state_reg != ST_IDLE);
    assign tx_len       = len_reg;
    assign grant_id     = grant_reg;
    assign zero_len_err = zerr_reg;
    assign c_tx_ack     = sel & {n_clients{ack_route}};
    assign c_tx_strobe  = sel & {n_clients{strobe_route & tx_strobe}};
    assign packet_out   = data_route ? byte_slot[grant_reg] : 8'h00;

endmodule
